// File: rtl/softmax_pkg.sv
// Shared types and constants for the 32-lane softmax engine, including the
// exponent ROM contents generator exp_q8 (used at elaboration time only).
package softmax_pkg;

   localparam int LANES = 32;
   localparam int DW    = 8;
   localparam int EW    = 11;
   localparam int SW    = 16;

   typedef enum logic [2:0] {IDLE, EXP, SUM, DIV, DONE} state_t;

   // round(256*e^(x/128)) via a Taylor series in Q40; only ever evaluated on constants
   function automatic logic [EW-1:0] exp_q8(input logic [DW-1:0] x);
      logic [63:0] term;
      logic [63:0] acc;
      term = 64'd1 << 40;
      acc  = term;
      for (int k = 1; k < 32; k++) begin
         term = (term * 64'(x)) / (64'(k) * 64'd128);
         acc  = acc + term;
      end
      return EW'((acc + (64'd1 << 31)) >> 32);
   endfunction

endpackage

// File: rtl/softmax_exp_lut.sv
// Combinational exponent ROM: 8-bit score -> 11-bit E = round(256*e^(x/128)).
module softmax_exp_lut
   import softmax_pkg::*;
(
   input  logic [DW-1:0] x,
   output logic [EW-1:0] e
);

   logic [EW-1:0] rom [256];

   for (genvar g = 0; g < 256; g++) begin : g_rom
      localparam logic [EW-1:0] VAL = exp_q8(DW'(g));
      assign rom[g] = VAL;
   end

   assign e = rom[x];

endmodule

// File: rtl/softmax32_unit.sv
// 32-lane 8-bit softmax engine: row register, EXP/SUM/DIV/DONE FSM, adder tree,
// 32 dividers. Define SOFTMAX_ROUND_EN for round-to-nearest division (clamped to 255).
module softmax32_unit
   import softmax_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  we,
   input  logic                  cme,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [LANES*DW-1:0]   cmIn,
   output logic [LANES*DW-1:0]   cmOut,
   output logic                  cmOutValid
);

   logic [LANES-1:0][DW-1:0] row_q;
   logic [LANES-1:0][EW-1:0] e_w;
   logic [LANES-1:0][EW-1:0] e_q;
   logic [LANES-1:0][DW-1:0] p_w;
   logic [SW-1:0]            sum_w;
   logic [SW-1:0]            sum_q;
   state_t                   state;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [EW+DW-1:0] num;

      softmax_exp_lut u_lut (
         .x (row_q[g]),
         .e (e_w[g])
      );

`ifdef SOFTMAX_ROUND_EN
      logic [EW+DW-1:0] quo;
      assign num      = {e_q[g], {DW{1'b0}}} + (EW+DW)'(sum_q >> 1);
      assign quo      = num / (EW+DW)'(sum_q);
      assign p_w[g]   = (quo > (EW+DW)'(255)) ? DW'(255) : quo[DW-1:0];
`else
      assign num      = {e_q[g], {DW{1'b0}}};
      assign p_w[g]   = DW'(num / (EW+DW)'(sum_q));
`endif
   end

   // Max sum is 32*1877 = 60064, so SW bits never overflow
   always_comb begin
      sum_w = '0;
      for (int i = 0; i < LANES; i++) sum_w = sum_w + SW'(e_q[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q      <= '0;
         e_q        <= '0;
         sum_q      <= '0;
         cmOut      <= '0;
         cmOutValid <= 1'b0;
         state      <= IDLE;
      end else if (en) begin
         if (we && addr == '0) begin
            row_q      <= cmIn;
            cmOutValid <= 1'b0;
            state      <= IDLE;
         end else begin
            case (state)
               IDLE: if (cme && !we) state <= EXP;
               EXP: begin
                  e_q   <= e_w;
                  state <= SUM;
               end
               SUM: begin
                  sum_q <= sum_w;
                  state <= DIV;
               end
               DIV: begin
                  cmOut <= p_w;
                  state <= DONE;
               end
               DONE: begin
                  if (cme) cmOutValid <= 1'b1;
                  else begin
                     cmOutValid <= 1'b0;
                     state      <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_softmax32_unit.sv
// Scoreboard bench for softmax32_unit: stimulus pushes expected rows, a negedge
// monitor pops and compares on each rising cmOutValid.
module tb_softmax32_unit;

   logic         clk = 1'b0;
   logic         rst, en, we, cme;
   logic [11:0]  addr;
   logic [255:0] cmIn, cmOut;
   logic         cmOutValid;

   int           total = 0;
   int           bad   = 0;
   logic [255:0] sb_q[$];
   logic         prev_v = 1'b0;

   typedef int row_t [32];

   softmax32_unit dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .we         (we),
      .cme        (cme),
      .addr       (addr),
      .cmIn       (cmIn),
      .cmOut      (cmOut),
      .cmOutValid (cmOutValid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (cmOutValid === 1'b1 && !prev_v) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got %h want none", cmOut);
         end else begin
            chk("result", cmOut, sb_q.pop_front());
         end
      end
      prev_v = (cmOutValid === 1'b1);
   end

   function automatic logic [255:0] splat(input int a, input int b);
      logic [255:0] r;
      for (int i = 0; i < 32; i++) r[8*i +: 8] = (i == 0) ? 8'(a) : 8'(b);
      return r;
   endfunction

   function automatic logic [255:0] pack_row(input row_t v);
      logic [255:0] r;
      for (int i = 0; i < 32; i++) r[8*i +: 8] = 8'(v[i]);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_row(input logic [255:0] r, input logic [11:0] a);
      we   = 1'b1;
      addr = a;
      cmIn = r;
      tick();
      we   = 1'b0;
      addr = '0;
   endtask

   // cme sampled at edge N; valid must be low after N+3 and high after N+4
   task automatic compute(input string name, input logic [255:0] e);
      sb_q.push_back(e);
      cme = 1'b1;
      tick();
      repeat (3) tick();
      chk({name, "_valid_early"}, {255'b0, cmOutValid}, 256'd0);
      tick();
      chk({name, "_valid_lat4"}, {255'b0, cmOutValid}, 256'd1);
      cme = 1'b0;
      tick();
      chk({name, "_valid_drop"}, {255'b0, cmOutValid}, 256'd0);
      chk({name, "_out_hold"}, cmOut, e);
   endtask

   task automatic run_row(input string name, input logic [255:0] r, input logic [255:0] e);
      write_row(r, 12'd0);
      compute(name, e);
   endtask

   logic [255:0] e_flat8, e_max0, e_mid0, e_t4;
   row_t t4_in  = '{247,112,1,233,240,149,171,21,196,60,7,201,88,159,157,38,
                    46,29,3,124,247,16,138,119,153,22,148,69,142,165,123,90};
   row_t t4_out = '{18,6,2,16,17,8,10,3,12,4,2,13,5,9,9,3,
                    3,3,2,7,18,3,8,6,9,3,8,4,8,9,7,5};

   initial begin
      e_flat8 = splat(8, 8);
`ifdef SOFTMAX_ROUND_EN
      e_max0  = splat(49, 7);
      e_mid0  = splat(21, 8);
`else
      e_max0  = splat(48, 6);
      e_mid0  = splat(20, 7);
`endif
      e_t4    = pack_row(t4_out);

      rst = 1'b1; en = 1'b1; we = 1'b0; cme = 1'b0; addr = '0; cmIn = '0;
      repeat (10) tick();
      chk("rst_out", cmOut, 256'd0);
      chk("rst_valid", {255'b0, cmOutValid}, 256'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_valid", {255'b0, cmOutValid}, 256'd0);

      run_row("all100", splat(100, 100), e_flat8);
      run_row("lane0_255", splat(255, 0), e_max0);
      run_row("lane0_128", splat(128, 0), e_mid0);

      // write to a non-zero address must not replace the row
      write_row(splat(100, 100), 12'd5);
      compute("addr_ignored", e_mid0);

`ifndef SOFTMAX_ROUND_EN
      run_row("mixed_row", pack_row(t4_in), e_t4);
`endif

      // abort: new write while in SUM, cme held high throughout
      write_row(splat(100, 100), 12'd0);
      cme = 1'b1;
      tick();
      tick();
      sb_q.push_back(e_max0);
      write_row(splat(255, 0), 12'd0);
      chk("abort_valid_w", {255'b0, cmOutValid}, 256'd0);
      repeat (4) tick();
      chk("abort_valid_early", {255'b0, cmOutValid}, 256'd0);
      tick();
      chk("abort_valid_lat4", {255'b0, cmOutValid}, 256'd1);
      cme = 1'b0;
      tick();
      chk("abort_valid_drop", {255'b0, cmOutValid}, 256'd0);

      // enable freeze while in DIV: cmOut keeps the previous result
      write_row(splat(100, 100), 12'd0);
      sb_q.push_back(e_flat8);
      cme = 1'b1;
      repeat (3) tick();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("freeze_valid", {255'b0, cmOutValid}, 256'd0);
         chk("freeze_out", cmOut, e_max0);
      end
      en = 1'b1;
      tick();
      chk("unfreeze_valid_1", {255'b0, cmOutValid}, 256'd0);
      tick();
      chk("unfreeze_valid_2", {255'b0, cmOutValid}, 256'd1);
      cme = 1'b0;
      tick();

      // reset mid-computation clears everything, including the row
      write_row(splat(255, 0), 12'd0);
      cme = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      cme = 1'b0;
      tick();
      chk("midrst_out", cmOut, 256'd0);
      chk("midrst_valid", {255'b0, cmOutValid}, 256'd0);
      rst = 1'b0;
      tick();
      compute("zero_row", e_flat8);

      repeat (3) tick();
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
